// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS fetch stage: reset PC, fetch FSM state
// type and encodings, instruction field widths, and the branch offset helper.
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam int unsigned OFFSET_W = 16;
  localparam int unsigned INDEX_W  = 26;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t RESET_WAIT = 2'd0;
  localparam fetch_state_t FETCH      = 2'd1;
  localparam fetch_state_t DELIVER    = 2'd2;

  // Sign-extended word offset converted to a byte displacement (<< 2).
  function automatic logic [31:0] sext_word_offset(input logic [OFFSET_W-1:0] off);
    return {{(32 - OFFSET_W - 2){off[OFFSET_W-1]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_if
// Bundle of the fetch stage's bus signals.
//   imem_*        : request/acknowledge fetch toward instruction memory
//   inst_*        : valid/ready delivery of one instruction to decode/execute
//   pc_plus4      : link value (inst_pc + 4)
//   branch_*/jump*: control from execute, sampled at retire only
// master = fetch unit side, slave = memory/execute side.
// -----------------------------------------------------------------------------
interface fetch_pc_unit_if;
  import mips_pkg::*;

  logic                imem_req;
  logic [31:0]         imem_addr;
  logic                imem_ack;
  logic [31:0]         imem_rdata;
  logic                inst_valid;
  logic                inst_ready;
  logic [31:0]         inst;
  logic [31:0]         inst_pc;
  logic [31:0]         pc_plus4;
  logic                branch_taken;
  logic [OFFSET_W-1:0] branch_offset;
  logic                jump;
  logic [INDEX_W-1:0]  jump_index;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, pc_plus4,
    input  imem_ack, imem_rdata, inst_ready,
           branch_taken, branch_offset, jump, jump_index
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc_plus4,
    output imem_ack, imem_rdata, inst_ready,
           branch_taken, branch_offset, jump, jump_index
  );

endinterface

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
// Purely combinational next-PC selection.
//   pc_plus4_i      : PC of the retiring instruction + 4
//   branch_offset_i : signed word offset (instr[15:0])
//   jump_index_i    : instr[25:0]
//   branch_taken_i  : Branch & Zero
//   jump_i          : j/jal decoded
//   next_pc_o       : jump target > branch target > pc_plus4
// -----------------------------------------------------------------------------
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0]         pc_plus4_i,
  input  logic [OFFSET_W-1:0] branch_offset_i,
  input  logic [INDEX_W-1:0]  jump_index_i,
  input  logic                branch_taken_i,
  input  logic                jump_i,
  output logic [31:0]         next_pc_o
);

  always_comb begin
    next_pc_o = pc_plus4_i;
    if (jump_i) begin
      next_pc_o = {pc_plus4_i[31:28], jump_index_i, 2'b00};
    end else if (branch_taken_i) begin
      next_pc_o = pc_plus4_i + sext_word_offset(branch_offset_i);
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// PC register and instruction fetch stage of the single-cycle MIPS CPU.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fetch_pc_unit_if.master (imem request/ack, instruction delivery,
//          branch/jump control sampled at retire)
// Sequence: RESET_WAIT -> FETCH (imem_req until imem_ack) -> DELIVER
// (inst_valid until inst_ready) -> FETCH at next_pc.
// All outputs come straight from flops; imem_addr is the PC register.
// -----------------------------------------------------------------------------
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
  input  logic            clk,
  input  logic            rst,
  fetch_pc_unit_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic [31:0]  pc_plus4_q, pc_plus4_d;
  logic         req_q, req_d;
  logic         valid_q, valid_d;
  logic [31:0]  next_pc;
  logic         retire;

  assign retire = valid_q & bus.inst_ready;

  next_pc_calc u_next_pc_calc (
    .pc_plus4_i      (pc_plus4_q),
    .branch_offset_i (bus.branch_offset),
    .jump_index_i    (bus.jump_index),
    .branch_taken_i  (bus.branch_taken),
    .jump_i          (bus.jump),
    .next_pc_o       (next_pc)
  );

  // req/valid are kept as dedicated flops rather than state decodes so that
  // every output is registered.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    pc_plus4_d = pc_plus4_q;
    req_d      = req_q;
    valid_d    = valid_q;
    case (state_q)
      RESET_WAIT: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        if (bus.imem_ack) begin
          inst_d     = bus.imem_rdata;
          inst_pc_d  = pc_q;
          pc_plus4_d = pc_q + 32'd4;
          req_d      = 1'b0;
          valid_d    = 1'b1;
          state_d    = DELIVER;
        end
      end
      DELIVER: begin
        if (retire) begin
          pc_d    = next_pc;
          req_d   = 1'b1;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = RESET_WAIT;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESET_WAIT;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      inst_pc_q  <= RESET_PC;
      pc_plus4_q <= RESET_PC + 32'd4;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      pc_plus4_q <= pc_plus4_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.pc_plus4   = pc_plus4_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
// Self-checking bench for fetch_pc_unit and the standalone next_pc_calc.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fetch_pc_unit_if bus_if ();

  fetch_pc_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  logic [31:0] n_pc4;
  logic [15:0] n_off;
  logic [25:0] n_idx;
  logic        n_bt;
  logic        n_j;
  logic [31:0] n_next;

  next_pc_calc u_npc (
    .pc_plus4_i      (n_pc4),
    .branch_offset_i (n_off),
    .jump_index_i    (n_idx),
    .branch_taken_i  (n_bt),
    .jump_i          (n_j),
    .next_pc_o       (n_next)
  );

  typedef struct {
    logic [31:0] pc4;
    logic [15:0] off;
    logic [25:0] idx;
    logic        bt;
    logic        j;
    logic [31:0] exp;
  } npc_vec_t;

  npc_vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference next-PC from the architectural rules, using wide signed math.
  function automatic logic [31:0] ref_target(input logic [31:0] pc4, input logic [15:0] off,
                                             input logic [25:0] idx, input logic bt, input logic j);
    longint t;
    if (j) return (pc4 & 32'hF000_0000) | (32'(idx) * 32'd4);
    if (bt) begin
      t = longint'(pc4) + longint'($signed(off)) * 4;
      return t[31:0];
    end
    return pc4;
  endfunction

  task automatic do_retire(input logic bt, input logic [15:0] off, input logic j, input logic [25:0] idx);
    bus_if.inst_ready    = 1'b1;
    bus_if.branch_taken  = bt;
    bus_if.branch_offset = off;
    bus_if.jump          = j;
    bus_if.jump_index    = idx;
    @(negedge clk);
    bus_if.inst_ready    = 1'b0;
    bus_if.branch_taken  = 1'b0;
    bus_if.branch_offset = '0;
    bus_if.jump          = 1'b0;
    bus_if.jump_index    = '0;
  endtask

  task automatic do_fetch(input string nm, input logic [31:0] addr, input logic [31:0] word);
    chk({nm, "_req"}, 32'(bus_if.imem_req), 32'd1);
    chk({nm, "_addr"}, bus_if.imem_addr, addr);
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = word;
    @(negedge clk);
    bus_if.imem_ack   = 1'b0;
    chk({nm, "_valid"}, 32'(bus_if.inst_valid), 32'd1);
    chk({nm, "_inst"}, bus_if.inst, word);
    chk({nm, "_inst_pc"}, bus_if.inst_pc, addr);
    chk({nm, "_pc_plus4"}, bus_if.pc_plus4, addr + 32'd4);
  endtask

  initial begin
    logic [31:0] m_fetch, m_pc, m_inst;
    logic        fetching;

    vecs[0] = '{32'h0000_3004, 16'h0000, 26'h0, 1'b0, 1'b0, 32'h0000_3004};
    vecs[1] = '{32'h0000_3014, 16'hFFFC, 26'h0, 1'b1, 1'b0, 32'h0000_3004};
    vecs[2] = '{32'h0000_3014, 16'hFFFC, 26'h0, 1'b0, 1'b0, 32'h0000_3014};
    vecs[3] = '{32'h0000_3014, 16'hFFFC, 26'h0000C10, 1'b1, 1'b1, 32'h0000_3040};
    vecs[4] = '{32'h0000_0000, 16'h0000, 26'h0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[5] = '{32'hFFFF_FFF0, 16'h0008, 26'h0, 1'b1, 1'b0, 32'h0000_0010};
    vecs[6] = '{32'hF000_0004, 16'h0000, 26'h3FFFFFF, 1'b0, 1'b1, 32'hFFFF_FFFC};
    vecs[7] = '{32'h0000_0010, 16'h8000, 26'h0, 1'b1, 1'b0, 32'hFFFE_0010};
    vecs[8] = '{32'h1000_0000, 16'h7FFF, 26'h0, 1'b1, 1'b0, 32'h1001_FFFC};
    vecs[9] = '{32'hABCD_1234, 16'h1234, 26'h0, 1'b0, 1'b1, 32'hA000_0000};

    rst                  = 1'b1;
    bus_if.imem_ack      = 1'b0;
    bus_if.imem_rdata    = '0;
    bus_if.inst_ready    = 1'b0;
    bus_if.branch_taken  = 1'b0;
    bus_if.branch_offset = '0;
    bus_if.jump          = 1'b0;
    bus_if.jump_index    = '0;

    // ---- standalone next_pc_calc: table then random ----
    for (int i = 0; i < 10; i++) begin
      n_pc4 = vecs[i].pc4; n_off = vecs[i].off; n_idx = vecs[i].idx;
      n_bt = vecs[i].bt; n_j = vecs[i].j;
      #1;
      chk($sformatf("npc_vec%0d", i), n_next, vecs[i].exp);
    end
    for (int i = 0; i < 200; i++) begin
      n_pc4 = $urandom & 32'hFFFF_FFFC; n_off = 16'($urandom); n_idx = 26'($urandom);
      n_bt = 1'($urandom); n_j = 1'($urandom);
      #1;
      chk("npc_rand", n_next, ref_target(n_pc4, n_off, n_idx, n_bt, n_j));
    end

    // ---- reset values ----
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(bus_if.imem_req), 32'd0);
    chk("rst_addr", bus_if.imem_addr, 32'h0000_3000);
    chk("rst_valid", 32'(bus_if.inst_valid), 32'd0);
    chk("rst_inst", bus_if.inst, 32'd0);
    chk("rst_inst_pc", bus_if.inst_pc, 32'h0000_3000);
    chk("rst_pc_plus4", bus_if.pc_plus4, 32'h0000_3004);

    // ---- release with zero-wait memory ----
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 32'h2008_0005;
    rst               = 1'b0;
    @(negedge clk);
    chk("rel_req", 32'(bus_if.imem_req), 32'd1);
    chk("rel_addr", bus_if.imem_addr, 32'h0000_3000);
    chk("rel_valid0", 32'(bus_if.inst_valid), 32'd0);
    @(negedge clk);
    chk("rel_valid", 32'(bus_if.inst_valid), 32'd1);
    chk("rel_inst", bus_if.inst, 32'h2008_0005);
    chk("rel_pc_plus4", bus_if.pc_plus4, 32'h0000_3004);
    chk("rel_req_off", 32'(bus_if.imem_req), 32'd0);

    // ---- sequential flow, ready held high ----
    bus_if.inst_ready = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("seq_req", 32'(bus_if.imem_req), 32'd1);
      chk("seq_addr", bus_if.imem_addr, 32'h0000_3000 + 32'(4 * k));
      @(negedge clk);
      chk("seq_valid", 32'(bus_if.inst_valid), 32'd1);
      chk("seq_inst_pc", bus_if.inst_pc, 32'h0000_3000 + 32'(4 * k));
    end
    bus_if.imem_ack   = 1'b0;
    bus_if.inst_ready = 1'b0;

    // ---- branch taken / not taken / jump wins ----
    do_retire(1'b0, 16'h0, 1'b1, 26'h0000C04);
    do_fetch("jmp3010a", 32'h0000_3010, 32'h1111_0001);
    do_retire(1'b1, 16'hFFFC, 1'b0, 26'h0);
    do_fetch("br_taken", 32'h0000_3004, 32'h1111_0002);
    do_retire(1'b0, 16'h0, 1'b1, 26'h0000C04);
    do_fetch("jmp3010b", 32'h0000_3010, 32'h1111_0003);
    do_retire(1'b0, 16'hFFFC, 1'b0, 26'h0);
    do_fetch("br_not", 32'h0000_3014, 32'h1111_0004);
    do_retire(1'b1, 16'hFFFC, 1'b1, 26'h0000C10);
    do_fetch("jmp_wins", 32'h0000_3040, 32'h1111_0005);

    // ---- memory stall ----
    do_retire(1'b0, 16'h0, 1'b0, 26'h0);
    for (int k = 0; k < 3; k++) begin
      chk("mstall_addr", bus_if.imem_addr, 32'h0000_3044);
      chk("mstall_req", 32'(bus_if.imem_req), 32'd1);
      chk("mstall_valid", 32'(bus_if.inst_valid), 32'd0);
      @(negedge clk);
    end
    do_fetch("mstall_done", 32'h0000_3044, 32'hCAFE_0001);

    // ---- consumer stall with stray ack ----
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cstall_valid", 32'(bus_if.inst_valid), 32'd1);
      chk("cstall_inst", bus_if.inst, 32'hCAFE_0001);
      chk("cstall_inst_pc", bus_if.inst_pc, 32'h0000_3044);
      chk("cstall_req", 32'(bus_if.imem_req), 32'd0);
    end
    bus_if.imem_ack = 1'b0;
    do_retire(1'b0, 16'h0, 1'b0, 26'h0);

    // ---- ready/jump outside DELIVER ignored ----
    bus_if.inst_ready = 1'b1;
    bus_if.jump       = 1'b1;
    bus_if.jump_index = 26'h0000100;
    @(negedge clk);
    bus_if.inst_ready = 1'b0;
    bus_if.jump       = 1'b0;
    bus_if.jump_index = '0;
    chk("ign_ready_addr", bus_if.imem_addr, 32'h0000_3048);
    chk("ign_ready_req", 32'(bus_if.imem_req), 32'd1);

    // ---- reset pulse mid-FETCH, ack on the release cycle ----
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(bus_if.imem_req), 32'd0);
    chk("arst_valid", 32'(bus_if.inst_valid), 32'd0);
    chk("arst_addr", bus_if.imem_addr, 32'h0000_3000);
    chk("arst_inst", bus_if.inst, 32'd0);
    chk("arst_pc_plus4", bus_if.pc_plus4, 32'h0000_3004);
    @(negedge clk);
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 32'hBADC_0DE0;
    rst               = 1'b0;
    @(negedge clk);
    bus_if.imem_ack = 1'b0;
    chk("arst_restart_req", 32'(bus_if.imem_req), 32'd1);
    chk("arst_restart_addr", bus_if.imem_addr, 32'h0000_3000);
    chk("arst_no_capture_valid", 32'(bus_if.inst_valid), 32'd0);
    chk("arst_no_capture_inst", bus_if.inst, 32'd0);

    // ---- randomized traffic against a transaction-level model ----
    m_fetch  = 32'h0000_3000;
    m_pc     = 32'h0000_3000;
    m_inst   = '0;
    fetching = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (fetching) begin
        chk("rnd_req", 32'(bus_if.imem_req), 32'd1);
        chk("rnd_addr", bus_if.imem_addr, m_fetch);
        chk("rnd_valid0", 32'(bus_if.inst_valid), 32'd0);
      end else begin
        chk("rnd_valid", 32'(bus_if.inst_valid), 32'd1);
        chk("rnd_req0", 32'(bus_if.imem_req), 32'd0);
        chk("rnd_inst", bus_if.inst, m_inst);
        chk("rnd_inst_pc", bus_if.inst_pc, m_pc);
        chk("rnd_pc_plus4", bus_if.pc_plus4, m_pc + 32'd4);
      end
      bus_if.imem_ack      = 1'($urandom);
      bus_if.imem_rdata    = $urandom;
      bus_if.inst_ready    = 1'($urandom);
      bus_if.branch_taken  = 1'($urandom);
      bus_if.branch_offset = 16'($urandom);
      bus_if.jump          = ($urandom_range(0, 3) == 0);
      bus_if.jump_index    = 26'($urandom);
      if (fetching && bus_if.imem_ack) begin
        m_inst   = bus_if.imem_rdata;
        m_pc     = m_fetch;
        fetching = 1'b0;
      end else if (!fetching && bus_if.inst_ready) begin
        m_fetch  = ref_target(m_pc + 32'd4, bus_if.branch_offset, bus_if.jump_index,
                              bus_if.branch_taken, bus_if.jump);
        fetching = 1'b1;
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and instruction-fetch stage of the single-cycle MIPS CPU. It holds the architectural PC, runs a request/acknowledge fetch against instruction memory, and presents one instruction at a time to decode/execute with a valid/ready handshake. It is the direct consumer of the branch-decision gate output (`Branch & Zero`) and uses it, together with the jump control, to select the next PC when the current instruction retires.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset; the first fetch address.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address, stable while `imem_req`=1.
- `imem_ack` in 1: memory response valid; `imem_rdata` is sampled on the same edge.
- `imem_rdata` in 32: instruction word.
- `inst_valid` out 1: `inst`/`inst_pc` hold a fetched instruction.
- `inst_ready` in 1: execute consumes the instruction (retire) this cycle.
- `inst` out 32: instruction word.
- `inst_pc` out 32: PC of `inst`.
- `pc_plus4` out 32: `inst_pc + 4`, used as the link value for jal.
- `branch_taken` in 1: output of the branch-decision AND gate; sampled only at retire.
- `branch_offset` in 16: signed word offset (instr[15:0]).
- `jump` in 1: j/jal decoded; sampled only at retire.
- `jump_index` in 26: instr[25:0].

## Operation
- FSM states are RESET_WAIT, FETCH, and DELIVER.
- RESET_WAIT: entered on reset. Outputs are idle. Moves to FETCH on the first clock edge after `rst` deasserts.
- FETCH: `imem_req`=1 and `imem_addr`=PC. On an edge with `imem_ack`=1, the block captures `imem_rdata` into `inst`, captures PC into `inst_pc`, and moves to DELIVER. Without ack it stays in FETCH, and the address is held.
- DELIVER: `inst_valid`=1. On an edge with `inst_ready`=1 (retire), the block loads PC with next_pc and moves to FETCH. Without ready it holds all outputs.
- The retire condition is `inst_valid & inst_ready`. `jump` and `branch_taken` are ignored outside retire.
- next_pc priority:
  - `jump`=1 selects `{pc_plus4[31:28], jump_index, 2'b00}`.
  - Otherwise `branch_taken`=1 selects `pc_plus4 + (sign_extend(branch_offset) << 2)`.
  - Otherwise next_pc is `pc_plus4`.
- Arithmetic is 32-bit modulo 2^32. Wrap-around from 32'hFFFF_FFFC to 0 is legal and needs no special handling. Targets are word-aligned by construction.
- `imem_ack` outside FETCH is ignored and changes no state.
- `inst_ready` outside DELIVER is ignored.
- `jump`=1 together with `branch_taken`=1: the jump wins.
- Reset mid-operation: asserting `rst` in any state immediately (asynchronously) drops `imem_req` and `inst_valid` and forces PC to `RESET_PC`. An ack pending at that time is discarded.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `inst_valid`=0, `inst`=0, `inst_pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4, state=RESET_WAIT.
- `imem_ack` may be high in the first FETCH cycle (zero-wait memory). The minimum fetch latency is therefore 1 cycle from entering FETCH to `inst_valid`.
- Peak throughput is one instruction per 2 cycles (FETCH, DELIVER).
- Every output is driven from a register, except `imem_addr`, which equals the PC register. There are no combinational paths from any input to any output.
- The PC updates on the retire edge. `imem_req` rises in the following cycle with the new `imem_addr`.

## Structure
- Shared package `mips_pkg` holds:
  - the `RESET_PC` default constant;
  - the FSM state typedef (RESET_WAIT, FETCH, DELIVER);
  - the instruction field width constants (OFFSET_W=16, INDEX_W=26).
- One sub-module, `next_pc_calc`, is purely combinational. It takes `pc_plus4`, `branch_offset`, `jump_index`, `branch_taken` and `jump`, and produces `next_pc`. It is verified standalone as well.

## Test plan
- Reset release, with memory acking immediately and `imem_rdata`=32'h2008_0005 → `imem_req`=1 with `imem_addr`=32'h0000_3000 one cycle after release; the next cycle `inst_valid`=1, `inst`=32'h2008_0005, `pc_plus4`=32'h0000_3004.
- Sequential flow with `inst_ready` held high and no branch → fetch addresses 3000, 3004, 3008 at 2-cycle spacing.
- `inst_pc`=32'h0000_3010, `branch_taken`=1, `branch_offset`=16'hFFFC at retire → next `imem_addr`=32'h0000_3004. Repeating this with `branch_taken`=0 → next `imem_addr`=32'h0000_3014.
- `jump`=1 and `branch_taken`=1 together, `jump_index`=26'h000_0C10 → next `imem_addr`=32'h0000_3040 (jump wins).
- Memory stall: `imem_ack` low for 3 cycles → `imem_addr` stable and `inst_valid`=0 throughout. Consumer stall: `inst_ready` low for 4 cycles → `inst` held, no new request, and a stray `imem_ack` is ignored.
- `rst` pulsed mid-FETCH, with `imem_ack` arriving in the same cycle as the deassertion → outputs return to reset values immediately, the ack is not captured, and the fetch restarts at `RESET_PC`.
